// File: rtl/adder_pkg.sv
// Shared definitions for the chunked serial adder: FSM encoding and a
// width helper for the chunk counter.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Bits needed to hold 0..value-1, never less than one bit so a
  // single-chunk configuration still gets a legal counter.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// CHUNK-bit ripple-carry cell shared by every chunk of the serial adder.
// Also exposes the carry into its top bit so the caller can form signed
// overflow on the final chunk.
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] carry;

  // Ripple the carry through the chunk one bit at a time.
  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]       = x[i] ^ y[i] ^ carry[i];
      carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end
    co       = carry[CHUNK];
    c_msb_in = carry[CHUNK-1];
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder that pushes CHUNK bits per clock through a
// single shared chunk_add cell. Operands are latched on accept, the sum is
// assembled in a work register and only published once complete, and the
// result is held until the consumer takes it.
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = clog2(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : gBadParams
    $error("chunked_serial_adder: illegal WIDTH/CHUNK combination");
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [CHUNK-1:0]  chunkX, chunkY, chunkS;
  logic              chunkCo, chunkMsbIn;

  // Select the operand chunk addressed by the counter.
  always_comb begin
    chunkX = a_q[cnt_q*CHUNK +: CHUNK];
    chunkY = b_q[cnt_q*CHUNK +: CHUNK];
  end

  chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .x        (chunkX),
    .y        (chunkY),
    .ci       (carry_q),
    .s        (chunkS),
    .co       (chunkCo),
    .c_msb_in (chunkMsbIn)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    work_d    = work_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        work_d[cnt_q*CHUNK +: CHUNK] = chunkS;
        carry_d = chunkCo;
        if (cnt_q == LAST) begin
          sum_d   = work_d;
          cout_d  = chunkCo;
          ovf_d   = chunkCo ^ chunkMsbIn;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed and swept checks of chunked_serial_adder. The main 16/4 instance
// takes the directed sequence; three more configurations run in lockstep
// with it for the random sweep.
module tb_chunked_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        swValid;
  logic [15:0] swA, swB;
  logic        swCin;
  logic        r11, v11, c11, o11;
  logic [0:0]  s11;
  logic        r81, v81, c81, o81;
  logic [7:0]  s81;
  logic        r88, v88, c88, o88;
  logic [7:0]  s88;

  int assertCount = 0;
  int failCount   = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  chunked_serial_adder #(.WIDTH(1), .CHUNK(1)) u11 (
    .clk(clk), .rst_n(rst_n), .in_valid(swValid), .in_ready(r11),
    .a(swA[0:0]), .b(swB[0:0]), .cin(swCin), .out_valid(v11), .out_ready(1'b1),
    .sum(s11), .cout(c11), .ovf(o11));

  chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) u81 (
    .clk(clk), .rst_n(rst_n), .in_valid(swValid), .in_ready(r81),
    .a(swA[7:0]), .b(swB[7:0]), .cin(swCin), .out_valid(v81), .out_ready(1'b1),
    .sum(s81), .cout(c81), .ovf(o81));

  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) u88 (
    .clk(clk), .rst_n(rst_n), .in_valid(swValid), .in_ready(r88),
    .a(swA[7:0]), .b(swB[7:0]), .cin(swCin), .out_valid(v88), .out_ready(1'b1),
    .sum(s88), .cout(c88), .ovf(o88));

  // Reference add of the low w bits: returns {ovf, cout, sum}.
  function automatic logic [17:0] refAdd(input int w, input logic [15:0] x,
                                         input logic [15:0] y, input logic c);
    logic [16:0] mask, full;
    logic [15:0] xm, ym, s;
    logic        co, ov;
    mask = (17'd1 << w) - 17'd1;
    xm   = x & mask[15:0];
    ym   = y & mask[15:0];
    full = {1'b0, xm} + {1'b0, ym} + {16'b0, c};
    s    = full[15:0] & mask[15:0];
    co   = full[w];
    ov   = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
    return {ov, co, s};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offer operands to the main instance, then scramble the ports and count
  // cycles (accept cycle = 0) until out_valid is seen.
  task automatic applyStimulus(input logic [15:0] aIn, input logic [15:0] bIn,
                               input logic cinIn, output int lat);
    int waitCnt;
    @(negedge clk);
    a = aIn; b = bIn; cin = cinIn; in_valid = 1'b1;
    waitCnt = 0;
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("accept_ready", {15'b0, in_ready}, 16'd1);
    @(negedge clk);
    in_valid = 1'b0; a = ~aIn; b = ~bIn; cin = ~cinIn;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [15:0] aIn, input logic [15:0] bIn,
                       input logic cinIn, input logic [15:0] expSum,
                       input logic expCout, input logic expOvf);
    int lat;
    applyStimulus(aIn, bIn, cinIn, lat);
    checkOutput({tag, "_lat"}, 16'(lat), 16'd5);
    checkOutput({tag, "_sum"}, sum, expSum);
    checkOutput({tag, "_cout"}, {15'b0, cout}, {15'b0, expCout});
    checkOutput({tag, "_ovf"}, {15'b0, ovf}, {15'b0, expOvf});
    @(negedge clk);
    checkOutput({tag, "_validlow"}, {15'b0, out_valid}, 16'd0);
    checkOutput({tag, "_readyhigh"}, {15'b0, in_ready}, 16'd1);
  endtask

  initial begin
    logic [15:0] capSum[4];
    logic        capC[4], capO[4];
    int          capLat[4];
    bit          got[4];
    int          widths[4];
    int          nchunks[4];
    logic [17:0] exp;
    logic [15:0] opA, opB;
    logic        opC;
    int          cyc, lat;

    widths  = '{16, 1, 8, 8};
    nchunks = '{4, 1, 8, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    swValid = 1'b0; swA = '0; swB = '0; swCin = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", {15'b0, in_ready}, 16'd1);
    checkOutput("rst_out_valid", {15'b0, out_valid}, 16'd0);
    checkOutput("rst_sum", sum, 16'd0);
    checkOutput("rst_cout", {15'b0, cout}, 16'd0);
    checkOutput("rst_ovf", {15'b0, ovf}, 16'd0);
    checkOutput("rst_sweep_ready", {13'b0, r11, r81, r88}, 16'h7);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    runOp("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    runOp("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    runOp("8000_p8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    runOp("zero_cin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    runOp("1234_4321", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    applyStimulus(16'hAAAA, 16'h5555, 1'b0, lat);
    checkOutput("bp_lat", 16'(lat), 16'd5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        in_valid = 1'b1; a = 16'h0001; b = 16'h0001;
      end
      if (i == 4) in_valid = 1'b0;
      if (i == 9) out_ready = 1'b1;
      checkOutput("bp_valid", {15'b0, out_valid}, 16'd1);
      checkOutput("bp_sum", sum, 16'hFFFF);
      checkOutput("bp_in_ready", {15'b0, in_ready}, 16'd0);
    end
    @(negedge clk);
    checkOutput("bp_release_valid", {15'b0, out_valid}, 16'd0);
    checkOutput("bp_release_ready", {15'b0, in_ready}, 16'd1);
    runOp("after_bp", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("[TB] reset during RUN");
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    checkOutput("abort_accept", {15'b0, in_ready}, 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", {15'b0, out_valid}, 16'd0);
    checkOutput("abort_sum", sum, 16'd0);
    checkOutput("abort_ready", {15'b0, in_ready}, 16'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("abort_no_result", {15'b0, out_valid}, 16'd0);
      checkOutput("abort_sum_hold", sum, 16'd0);
    end

    $display("[TB] parameter sweep");
    for (int it = 0; it < 500; it++) begin
      opA = 16'($urandom);
      opB = 16'($urandom);
      opC = 1'($urandom);
      @(negedge clk);
      a = opA; b = opB; cin = opC; in_valid = 1'b1;
      swA = opA; swB = opB; swCin = opC; swValid = 1'b1;
      checkOutput("sweep_ready", {12'b0, in_ready, r11, r81, r88}, 16'hF);
      @(negedge clk);
      in_valid = 1'b0; swValid = 1'b0;
      a = ~opA; b = ~opB; swA = ~opA; swB = ~opB;
      for (int k = 0; k < 4; k++) begin
        got[k] = 1'b0; capLat[k] = 0; capSum[k] = '0; capC[k] = 1'b0; capO[k] = 1'b0;
      end
      cyc = 1;
      while (cyc < 40) begin
        if (out_valid && !got[0]) begin
          got[0] = 1'b1; capLat[0] = cyc; capSum[0] = sum; capC[0] = cout; capO[0] = ovf;
        end
        if (v11 && !got[1]) begin
          got[1] = 1'b1; capLat[1] = cyc; capSum[1] = {15'b0, s11}; capC[1] = c11; capO[1] = o11;
        end
        if (v81 && !got[2]) begin
          got[2] = 1'b1; capLat[2] = cyc; capSum[2] = {8'b0, s81}; capC[2] = c81; capO[2] = o81;
        end
        if (v88 && !got[3]) begin
          got[3] = 1'b1; capLat[3] = cyc; capSum[3] = {8'b0, s88}; capC[3] = c88; capO[3] = o88;
        end
        if (got[0] && got[1] && got[2] && got[3]) break;
        @(negedge clk);
        cyc++;
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        exp = refAdd(widths[k], opA, opB, opC);
        checkOutput($sformatf("sweep%0d_lat", k), 16'(capLat[k]), 16'(nchunks[k] + 1));
        checkOutput($sformatf("sweep%0d_sum", k), capSum[k], exp[15:0]);
        checkOutput($sformatf("sweep%0d_cout", k), {15'b0, capC[k]}, {15'b0, exp[16]});
        checkOutput($sformatf("sweep%0d_ovf", k), {15'b0, capO[k]}, {15'b0, exp[17]});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
